// File: rtl/fft_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fft_pkg                                                     |
// | Purpose : Shared constants, bank-state encoding and index bit-reverse |
// |           helper for the FFT front-end blocks.                        |
// | Revision: 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package fft_pkg;

  localparam int FFT_N      = 8;
  localparam int FFT_LOG2N  = 3;
  localparam int FFT_DATA_W = 8;

  // Life cycle of one frame bank: written up to full, then read out.
  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  // Reverse the low 'width' bits of idx. Reversing the whole word and then
  // shifting right keeps the function independent of the frame length.
  function automatic logic [31:0] bitrev(input logic [31:0] idx,
                                         input int unsigned width);
    logic [31:0] r;
    r = {<<{idx}};
    return r >> (32 - width);
  endfunction

endpackage : fft_pkg
`default_nettype wire

// File: rtl/fft_frame_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fft_frame_bank                                              |
// | Purpose : One N-entry sample bank with its EMPTY/FILLING/FULL/        |
// |           DRAINING state register.                                    |
// | Ports   : clk, clear_n        clock, async active-low clear           |
// |           wr_en_i/wr_idx_i/wr_data_i/wr_last_i   write port           |
// |           rd_en_i/rd_last_i   read transfer strobes                   |
// |           rd_addr_i/rd_data_o combinational read port                 |
// |           state_o             current bank state                      |
// | Revision: 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter  int DATA_W = FFT_DATA_W,
  parameter  int N      = FFT_N,
  localparam int LOG2N  = $clog2(N)
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              wr_en_i,
  input  logic [LOG2N-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_last_i,
  input  logic              rd_en_i,
  input  logic              rd_last_i,
  input  logic [LOG2N-1:0]  rd_addr_i,
  output logic [1:0]        state_o,
  output logic [DATA_W-1:0] rd_data_o
);

  bank_state_e       state_q, state_d;
  logic [DATA_W-1:0] mem_q [N];

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= BANK_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BANK_EMPTY:    if (wr_en_i) state_d = wr_last_i ? BANK_FULL : BANK_FILLING;
      BANK_FILLING:  if (wr_en_i && wr_last_i) state_d = BANK_FULL;
      BANK_FULL:     if (rd_en_i) state_d = rd_last_i ? BANK_EMPTY : BANK_DRAINING;
      BANK_DRAINING: if (rd_en_i && rd_last_i) state_d = BANK_EMPTY;
      default:       state_d = BANK_EMPTY;
    endcase
  end

  // Storage is cleared too, so out_data reads 0 after a clear.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign state_o   = state_q;
  assign rd_data_o = mem_q[rd_addr_i];

endmodule : fft_frame_bank
`default_nettype wire

// File: rtl/fft_input_framer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fft_input_framer                                            |
// | Purpose : Ping-pong framer ahead of the FFT. Collects N samples per   |
// |           bank and replays each full frame with SOF/EOF markers.      |
// | Ports   : clk, clear_n                 clock, async active-low clear  |
// |           in_valid/in_ready/in_data    sample input handshake         |
// |           out_valid/out_ready/out_data frame output handshake         |
// |           out_sof/out_eof              frame markers (valid-qualified)|
// | Build   : FFT_FRAMER_BITREV_EN defined -> read order is bit-reversed; |
// |           undefined -> natural order.                                 |
// | Revision: 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module fft_input_framer
  import fft_pkg::*;
#(
  parameter  int DATA_W = FFT_DATA_W,
  parameter  int N      = FFT_N,
  localparam int LOG2N  = $clog2(N)
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eof
);

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  logic             wr_bank_q, wr_bank_d;
  logic [LOG2N-1:0] wr_idx_q,  wr_idx_d;
  logic             rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0] rd_idx_q,  rd_idx_d;

  logic [1:0]        bank_state   [2];
  logic [DATA_W-1:0] bank_rd_data [2];

  logic             wr_fire, wr_last;
  logic             rd_fire, rd_last;
  logic [LOG2N-1:0] rd_addr;

  // A bank is either being written or being read, never both, so the
  // write and read pointers can safely land on the same bank index.
  assign in_ready  = (bank_state[wr_bank_q] == BANK_EMPTY) ||
                     (bank_state[wr_bank_q] == BANK_FILLING);
  assign out_valid = (bank_state[rd_bank_q] == BANK_FULL) ||
                     (bank_state[rd_bank_q] == BANK_DRAINING);

  assign wr_fire = in_valid && in_ready;
  assign wr_last = (wr_idx_q == LAST_IDX);
  assign rd_fire = out_valid && out_ready;
  assign rd_last = (rd_idx_q == LAST_IDX);

`ifdef FFT_FRAMER_BITREV_EN
  assign rd_addr = LOG2N'(bitrev(32'(rd_idx_q), LOG2N));
`else
  assign rd_addr = rd_idx_q;
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_bank #(
      .DATA_W (DATA_W),
      .N      (N)
    ) u_bank (
      .clk       (clk),
      .clear_n   (clear_n),
      .wr_en_i   (wr_fire && (wr_bank_q == 1'(b))),
      .wr_idx_i  (wr_idx_q),
      .wr_data_i (in_data),
      .wr_last_i (wr_last),
      .rd_en_i   (rd_fire && (rd_bank_q == 1'(b))),
      .rd_last_i (rd_last),
      .rd_addr_i (rd_addr),
      .state_o   (bank_state[b]),
      .rd_data_o (bank_rd_data[b])
    );
  end

  assign out_data = bank_rd_data[rd_bank_q];
  assign out_sof  = (rd_idx_q == '0);
  assign out_eof  = rd_last;

  // N is a power of two, so the index increments wrap to 0 on their own.
  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    rd_idx_d  = rd_idx_q;
    rd_bank_d = rd_bank_q;
    if (wr_fire) begin
      wr_idx_d = wr_idx_q + LOG2N'(1);
      if (wr_last) wr_bank_d = ~wr_bank_q;
    end
    if (rd_fire) begin
      rd_idx_d = rd_idx_q + LOG2N'(1);
      if (rd_last) rd_bank_d = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      wr_idx_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_idx_q  <= '0;
      rd_bank_q <= 1'b0;
    end else begin
      wr_idx_q  <= wr_idx_d;
      wr_bank_q <= wr_bank_d;
      rd_idx_q  <= rd_idx_d;
      rd_bank_q <= rd_bank_d;
    end
  end

endmodule : fft_input_framer
`default_nettype wire

// File: tb/tb_fft_input_framer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module  : tb_fft_input_framer                                         |
// | Purpose : Scoreboard bench for fft_input_framer (both read orders).   |
// | Revision: 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_fft_input_framer;

  localparam int NN = 8;

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_sof;
  logic       out_eof;

  always #5 clk = ~clk;

  fft_input_framer #(.DATA_W(8), .N(NN)) dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .out_eof   (out_eof)
  );

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q [$];
  logic [7:0] src   [$];
  logic [7:0] frame_buf [NN];
  int         ord [NN];
  int         fill = 0;
  int         out_pos = 0;
  int         n_out = 0;
  logic       s_in_ready, s_out_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  // One clock: drive inputs, sample at the falling edge, update scoreboard,
  // then advance to just after the next rising edge.
  task automatic cycle(input logic iv, input logic [7:0] d, input logic ordy);
    logic [7:0] w;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    if (out_valid && out_ready) begin
      n_out++;
      chk("q_has_data", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        chk("data", 32'(out_data), 32'(w));
      end
      chk("sof", 32'(out_sof), 32'(out_pos == 0));
      chk("eof", 32'(out_eof), 32'(out_pos == NN - 1));
      out_pos = (out_pos + 1) % NN;
    end
    if (in_valid && in_ready) begin
      frame_buf[fill] = in_data;
      fill++;
      if (fill == NN) begin
        for (int k = 0; k < NN; k++) exp_q.push_back(frame_buf[ord[k]]);
        fill = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic ordy, input int max_cyc);
    int c = 0;
    while (src.size() > 0 && c < max_cyc) begin
      cycle(1'b1, src[0], ordy);
      if (s_in_ready) void'(src.pop_front());
      c++;
    end
    chk("feed_done", 32'(src.size()), 32'd0);
  endtask

  task automatic drain(input int max_cyc);
    int c = 0;
    while (exp_q.size() > 0 && c < max_cyc) begin
      cycle(1'b0, 8'h00, 1'b1);
      c++;
    end
    chk("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic async_clear(input string tag);
    #2;
    clear_n = 1'b0;
    #1;
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"},  32'(out_data),  32'd0);
    chk({tag, "_sof"},       32'(out_sof),   32'd1);
    exp_q.delete();
    fill    = 0;
    out_pos = 0;
    @(posedge clk);
    #1;
    clear_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int bubbles;
    int stalls;
    int n0;

`ifdef FFT_FRAMER_BITREV_EN
    ord = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    for (int k = 0; k < NN; k++) ord[k] = k;
`endif

    // Reset state
    #2;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_sof",       32'(out_sof),   32'd1);
    chk("rst_eof",       32'(out_eof),   32'd0);
    @(posedge clk);
    #1;
    clear_n = 1'b1;

    // Single frame, latency, ordering
    src = '{8'h04, 8'h01, 8'h02, 8'hFD, 8'h01, 8'hFE, 8'h00, 8'h03};
    feed(1'b1, 20);
    chk("lat_early", 32'(s_out_valid), 32'd0);
    chk("lat_valid", 32'(out_valid),   32'd1);
    n0 = n_out;
    drain(20);
    chk("f1_count", 32'(n_out - n0), 32'd8);

    // Backpressure: two frames fill, third blocks
    for (int k = 0; k < 3 * NN; k++) begin
      if (k < NN) src.push_back((k == 0) ? 8'h04 : 8'(k * 9 + 1));
      else        src.push_back(8'(k * 13 + 5));
    end
    acc = 0;
    for (int c = 0; c < 30; c++) begin
      cycle(1'b1, src[0], 1'b0);
      if (s_in_ready) begin
        void'(src.pop_front());
        acc++;
      end
      if (c == 20) chk("bp_hold_mid", 32'(out_data), 32'h04);
    end
    chk("bp_accepted", 32'(acc), 32'd16);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_hold", 32'(out_data), 32'h04);
    chk("bp_valid", 32'(out_valid), 32'd1);
    acc = 0;
    for (int c = 0; c < NN; c++) begin
      cycle(1'b1, src[0], 1'b1);
      if (s_in_ready) begin
        void'(src.pop_front());
        acc++;
      end
    end
    chk("bp_no_accept_while_full", 32'(acc), 32'd0);
    chk("bp_release", 32'(in_ready), 32'd1);
    feed(1'b1, 40);
    drain(40);

    // Continuous streaming, four frames
    for (int k = 0; k < 4 * NN; k++) src.push_back(8'(k * 7 + 3));
    bubbles = 0;
    stalls  = 0;
    n0 = n_out;
    for (int j = 0; j < 5 * NN; j++) begin
      if (j < 4 * NN) cycle(1'b1, src[0], 1'b1);
      else            cycle(1'b0, 8'h00, 1'b1);
      if (j < 4 * NN) begin
        if (s_in_ready) void'(src.pop_front());
        else            stalls++;
      end
      if (j >= NN && !s_out_valid) bubbles++;
    end
    chk("cont_stalls",  32'(stalls),      32'd0);
    chk("cont_bubbles", 32'(bubbles),     32'd0);
    chk("cont_count",   32'(n_out - n0),  32'd32);
    chk("cont_q_empty", 32'(exp_q.size()), 32'd0);

    // Clear after a partial frame
    src = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    feed(1'b1, 20);
    async_clear("clr_partial");

    // Clear mid-drain
    src = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    feed(1'b1, 20);
    for (int c = 0; c < 3; c++) cycle(1'b0, 8'h00, 1'b1);
    async_clear("clr_drain");
    cycle(1'b0, 8'h00, 1'b1);
    chk("clr_idle", 32'(s_out_valid), 32'd0);

    // Fresh frame after clear
    src = '{8'h7F, 8'h80, 8'h01, 8'hFF, 8'h10, 8'h20, 8'h30, 8'h40};
    n0 = n_out;
    feed(1'b1, 20);
    drain(20);
    chk("post_clr_count", 32'(n_out - n0), 32'd8);
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fft_input_framer
`default_nettype wire
